ad7276_emu: RTL and testbench

- Single-clock behavioural-RTL model of the AD7276 serial ADC output stage, i.e. the slave end of the ADC CS/SCLK/SDATA link.
- Oversamples the master's cs_i and sclk_i in the fpga_clk_i domain and shifts out 16-bit frames: 2 leading zeros, 12-bit sample MSB first, 2 trailing zeros.
- Sample values come from a one-deep valid/ready input buffer.
- Used for hardware-in-the-loop loopback of the ADC capture path and as the bench stimulus model.

---
 rtl/ad7276_pkg.sv | 26 ++
 rtl/ad7276_emu_sync.sv | 50 +++++
 rtl/ad7276_emu.sv | 158 +++++++++++++++
 tb/tb_ad7276_emu.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ad7276_pkg.sv
// ad7276_pkg
// Shared constants, the frame-layout helper and the one-hot state encoding
// for the AD7276 serial-output emulator.
`timescale 1ns/1ps

package ad7276_pkg;

  // Default frame layout of the AD7276: 2 zeros, 12 data bits, 2 zeros.
  localparam int AD_DATA_WIDTH = 12;
  localparam int AD_LEAD_ZEROS = 2;
  localparam int AD_FRAME_BITS = 16;
  localparam int AD_SYNC_STAGES = 2;

  // Zero bits that follow the data LSB in a frame.
  function automatic int trail_zeros(input int frame_bits, input int lead_zeros,
                                     input int data_width);
    return frame_bits - lead_zeros - data_width;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_SHIFT = 3'b010,
    ST_DONE  = 3'b100
  } state_t;

endpackage

// File: rtl/ad7276_emu_sync.sv
// ad7276_emu_sync
// Brings one asynchronous bus pin into the fpga_clk_i domain and reports
// its changes.
// Ports:
//   fpga_clk_i  clock
//   reset_i     synchronous active-high reset
//   pin_i       asynchronous pin (idle high)
//   level_o     synchronized level, aligned with edge_o
//   edge_o      1-cycle strobe: level_o differs from its previous value
//               (rise = edge_o & level_o, fall = edge_o & ~level_o)
// The strobe appears after SYNC_STAGES flops; the consumer registers the
// reaction on the following clock, SYNC_STAGES+1 clocks after the pin edge.
`timescale 1ns/1ps

module ad7276_emu_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic fpga_clk_i,
  input  logic reset_i,
  input  logic pin_i,
  output logic level_o,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  // Marks when every flop holds a genuine pin sample rather than its reset
  // value; until then no strobe is reported, so a pin held low through
  // reset does not look like a fresh falling edge.
  logic [SYNC_STAGES:0]   fill_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours; blocking here would collapse the
  // synchronizer chain into a single stage.
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      sync_q <= '1;
      edge_q <= 1'b1;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      edge_q <= sync_q[SYNC_STAGES-1];
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign edge_o  = fill_q[SYNC_STAGES] & (sync_q[SYNC_STAGES-1] ^ edge_q);

endmodule

// File: rtl/ad7276_emu.sv
// ad7276_emu
// Behavioural model of the AD7276 serial output stage (slave side of the
// CS/SCLK/SDATA link). Each frame is LEAD_ZEROS zeros, the held sample MSB
// first, then trailing zeros; data changes after each falling SCLK.
// Ports:
//   fpga_clk_i      single clock
//   reset_i         synchronous active-high reset
//   sample_i        next conversion result
//   sample_valid_i  sample_i valid
//   sample_ready_o  next-sample buffer empty
//   cs_i            chip select, active low, asynchronous
//   sclk_i          serial clock, idles high, asynchronous
//   sdata_o         serial data
//   sdata_oe_o      output enable (low = three-state)
//   busy_o          frame in progress
//   frame_done_o    pulse: full frame shifted
//   frame_abort_o   pulse: CS rose mid-frame
//   underrun_o      pulse: frame started without a new sample
`timescale 1ns/1ps

module ad7276_emu
  import ad7276_pkg::*;
#(
  parameter int DATA_WIDTH  = AD_DATA_WIDTH,
  parameter int LEAD_ZEROS  = AD_LEAD_ZEROS,
  parameter int FRAME_BITS  = AD_FRAME_BITS,
  parameter int SYNC_STAGES = AD_SYNC_STAGES
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  sample_valid_i,
  output logic                  sample_ready_o,
  input  logic                  cs_i,
  input  logic                  sclk_i,
  output logic                  sdata_o,
  output logic                  sdata_oe_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  frame_abort_o,
  output logic                  underrun_o
);

  localparam int TRAIL_ZEROS = trail_zeros(FRAME_BITS, LEAD_ZEROS, DATA_WIDTH);
  localparam int CNT_W       = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  // Places a sample at its bit position inside a frame, zeros elsewhere.
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [DATA_WIDTH-1:0] s);
    logic [FRAME_BITS-1:0] w;
    w = '0;
    w[TRAIL_ZEROS +: DATA_WIDTH] = s;
    return w;
  endfunction

  logic cs_level, cs_edge, sclk_level, sclk_edge;
  logic cs_fall, cs_rise, sclk_fall;

  ad7276_emu_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .fpga_clk_i (fpga_clk_i),
    .reset_i    (reset_i),
    .pin_i      (cs_i),
    .level_o    (cs_level),
    .edge_o     (cs_edge)
  );

  ad7276_emu_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .fpga_clk_i (fpga_clk_i),
    .reset_i    (reset_i),
    .pin_i      (sclk_i),
    .level_o    (sclk_level),
    .edge_o     (sclk_edge)
  );

  assign cs_fall   = cs_edge & ~cs_level;
  assign cs_rise   = cs_edge & cs_level;
  assign sclk_fall = sclk_edge & ~sclk_level;

  state_t                state_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] held_q;
  logic [DATA_WIDTH-1:0] next_q;

  // sample_ready_o doubles as the "next buffer empty" flag.
  always_ff @(posedge fpga_clk_i) begin
    if (reset_i) begin
      state_q        <= ST_IDLE;
      // NOTE: the data registers are reset too: held_q must read 0 so a
      // frame started before any sample was written shifts out zeros.
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      held_q         <= '0;
      next_q         <= '0;
      sample_ready_o <= 1'b1;
      sdata_o        <= 1'b0;
      sdata_oe_o     <= 1'b0;
      busy_o         <= 1'b0;
      frame_done_o   <= 1'b0;
      frame_abort_o  <= 1'b0;
      underrun_o     <= 1'b0;
    end else begin
      frame_done_o  <= 1'b0;
      frame_abort_o <= 1'b0;
      underrun_o    <= 1'b0;

      // A sample taken in the same cycle as cs_fall sees ready=1 (buffer
      // empty), so that frame underruns and the sample waits for the next.
      if (sample_valid_i && sample_ready_o) begin
        next_q         <= sample_i;
        sample_ready_o <= 1'b0;
      end

      // NOTE: the default arm catches illegal one-hot codes and recovers
      // to IDLE instead of leaving the machine stuck.
      unique case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            if (!sample_ready_o) begin
              held_q         <= next_q;
              shift_q        <= frame_word(next_q);
              sample_ready_o <= 1'b1;
            end else begin
              shift_q    <= frame_word(held_q);
              underrun_o <= 1'b1;
            end
            bit_cnt_q <= '0;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // CS rising wins over a coincident final SCLK fall.
          if (cs_rise) begin
            frame_abort_o <= 1'b1;
            state_q       <= ST_IDLE;
          end else if (sclk_fall) begin
            shift_q   <= {shift_q[FRAME_BITS-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              frame_done_o <= 1'b1;
              state_q      <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (cs_rise) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      // Pin-side outputs follow the state one clock later.
      sdata_oe_o <= (state_q == ST_SHIFT);
      busy_o     <= (state_q == ST_SHIFT);
      sdata_o    <= (state_q == ST_SHIFT) && shift_q[FRAME_BITS-1];
    end
  end

endmodule

// File: tb/tb_ad7276_emu.sv
`timescale 1ns/1ps

module tb_ad7276_emu;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [11:0] sample_i = '0;
  logic        sample_valid_i = 1'b0;
  logic        sample_ready_o;
  logic        cs_i = 1'b1;
  logic        sclk_i = 1'b1;
  logic        sdata_o, sdata_oe_o, busy_o;
  logic        frame_done_o, frame_abort_o, underrun_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Pulse / activity counters, sampled on the falling clock edge.
  int   done_cnt = 0, abort_cnt = 0, under_cnt = 0, oe_rise_cnt = 0;
  logic oe_prev = 1'b0;

  always #5 clk = ~clk;  // 100 MHz

  ad7276_emu dut (
    .fpga_clk_i     (clk),
    .reset_i        (reset_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .cs_i           (cs_i),
    .sclk_i         (sclk_i),
    .sdata_o        (sdata_o),
    .sdata_oe_o     (sdata_oe_o),
    .busy_o         (busy_o),
    .frame_done_o   (frame_done_o),
    .frame_abort_o  (frame_abort_o),
    .underrun_o     (underrun_o)
  );

  always @(negedge clk) begin
    if (!reset_i) begin
      if (frame_done_o)  done_cnt  <= done_cnt + 1;
      if (frame_abort_o) abort_cnt <= abort_cnt + 1;
      if (underrun_o)    under_cnt <= under_cnt + 1;
      if (sdata_oe_o && !oe_prev) oe_rise_cnt <= oe_rise_cnt + 1;
      oe_prev <= sdata_oe_o;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic write_sample(input logic [11:0] v);
    @(negedge clk);
    sample_i       = v;
    sample_valid_i = 1'b1;
    @(negedge clk);
    sample_valid_i = 1'b0;
  endtask

  // Master side: CS low, n SCLK pulses (50 ns low / 50 ns high), capture
  // SDATA at each falling edge, CS high, settle. Returns the captured bits
  // (last capture in bit 0) and how many captures saw the output disabled.
  task automatic run_frame(input int n_falls, output logic [31:0] word, output int oe_low);
    word   = '0;
    oe_low = 0;
    @(posedge clk); #2;
    cs_i = 1'b0;
    #100;
    for (int i = 0; i < n_falls; i++) begin
      word = {word[30:0], sdata_o};
      if (!sdata_oe_o) oe_low++;
      sclk_i = 1'b0; #50;
      sclk_i = 1'b1; #50;
    end
    cs_i = 1'b1;
    #100;
  endtask

  typedef struct {
    logic        do_write;
    logic [11:0] sample;
    logic [15:0] exp_word;
    int          exp_under;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] word;
    int          oe_low;
    int          d0, a0, u0, r0;

    vecs[0] = '{1'b0, 12'h000, 16'h0000, 1};  // empty from reset
    vecs[1] = '{1'b1, 12'hABC, 16'h2AF0, 0};
    vecs[2] = '{1'b0, 12'h000, 16'h2AF0, 1};  // repeat without new sample
    vecs[3] = '{1'b1, 12'h001, 16'h0004, 0};
    vecs[4] = '{1'b1, 12'h800, 16'h2000, 0};
    vecs[5] = '{1'b1, 12'h555, 16'h1554, 0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset outputs {ready,sdata,oe,busy,done,abort,under}",
          {25'd0, sample_ready_o, sdata_o, sdata_oe_o, busy_o, frame_done_o,
           frame_abort_o, underrun_o}, 32'b1000000);
    reset_i = 1'b0;
    repeat (10) @(negedge clk);
    check("idle oe after reset", {31'd0, sdata_oe_o}, 32'd0);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_write) begin
        write_sample(vecs[i].sample);
        check($sformatf("vec%0d ready after write", i), {31'd0, sample_ready_o}, 32'd0);
      end
      d0 = done_cnt; a0 = abort_cnt; u0 = under_cnt;
      run_frame(16, word, oe_low);
      check($sformatf("vec%0d word", i), {16'd0, word[15:0]}, {16'd0, vecs[i].exp_word});
      check($sformatf("vec%0d underrun", i), under_cnt - u0, vecs[i].exp_under);
      check($sformatf("vec%0d done", i), done_cnt - d0, 1);
      check($sformatf("vec%0d abort", i), abort_cnt - a0, 0);
      check($sformatf("vec%0d oe low during capture", i), oe_low, 0);
      check($sformatf("vec%0d oe after frame", i), {31'd0, sdata_oe_o}, 32'd0);
      check($sformatf("vec%0d ready after frame", i), {31'd0, sample_ready_o}, 32'd1);
    end

    // Write 0x123 while a 0xFFF frame is shifting.
    write_sample(12'hFFF);
    u0 = under_cnt;
    fork
      run_frame(16, word, oe_low);
      begin
        #700;
        write_sample(12'h123);
        check("mid-frame ready after write", {31'd0, sample_ready_o}, 32'd0);
      end
    join
    check("mid-frame current word", {16'd0, word[15:0]}, 32'h3FFC);
    check("mid-frame ready before next cs", {31'd0, sample_ready_o}, 32'd0);
    run_frame(16, word, oe_low);
    check("mid-frame next word", {16'd0, word[15:0]}, 32'h048C);
    check("mid-frame underruns", under_cnt - u0, 0);

    // Abort after 7 SCLK falls.
    write_sample(12'h5A5);
    d0 = done_cnt; a0 = abort_cnt;
    @(posedge clk); #2;
    cs_i = 1'b0;
    #100;
    for (int i = 0; i < 7; i++) begin
      sclk_i = 1'b0; #50;
      sclk_i = 1'b1; #50;
    end
    check("abort oe before cs rise", {31'd0, sdata_oe_o}, 32'd1);
    cs_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort oe low within 4 clocks", {31'd0, sdata_oe_o}, 32'd0);
    #100;
    check("abort pulse", abort_cnt - a0, 1);
    check("abort no done", done_cnt - d0, 0);
    u0 = under_cnt;
    run_frame(16, word, oe_low);
    check("after abort word restarts", {16'd0, word[15:0]}, 32'h1694);
    check("after abort underrun", under_cnt - u0, 1);

    // 20 SCLK pulses in one frame.
    write_sample(12'h3C3);
    d0 = done_cnt; a0 = abort_cnt; r0 = oe_rise_cnt;
    run_frame(20, word, oe_low);
    check("20clk word", {12'd0, word[19:0]}, 32'h0000F0C0);
    check("20clk done", done_cnt - d0, 1);
    check("20clk abort", abort_cnt - a0, 0);
    check("20clk oe low on extra edges", oe_low, 4);
    check("20clk single oe window", oe_rise_cnt - r0, 1);

    // Reset mid-frame with CS held low.
    write_sample(12'h777);
    @(posedge clk); #2;
    cs_i = 1'b0;
    #100;
    repeat (5) begin
      sclk_i = 1'b0; #50;
      sclk_i = 1'b1; #50;
    end
    check("oe before mid-frame reset", {31'd0, sdata_oe_o}, 32'd1);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    check("mid-frame reset outputs",
          {25'd0, sample_ready_o, sdata_o, sdata_oe_o, busy_o, frame_done_o,
           frame_abort_o, underrun_o}, 32'b1000000);
    @(negedge clk);
    reset_i = 1'b0;
    d0 = done_cnt; r0 = oe_rise_cnt; u0 = under_cnt;
    repeat (20) begin
      sclk_i = 1'b0; #50;
      sclk_i = 1'b1; #50;
    end
    check("cs held low: no oe", oe_rise_cnt - r0, 0);
    check("cs held low: no done", done_cnt - d0, 0);
    check("cs held low: no underrun", under_cnt - u0, 0);
    cs_i = 1'b1;
    #200;
    u0 = under_cnt;
    run_frame(16, word, oe_low);
    check("post-reset frame word", {16'd0, word[15:0]}, 32'h0000);
    check("post-reset underrun", under_cnt - u0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
